// File: rtl/fft_pkg.sv
// Shared constants, types and complex word helpers for the FFT datapath.
// A complex word packs real in the upper half and imag in the lower half.
package fft_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int FRAME_LEN   = 64;
    localparam int SCALE_SHIFT = 6;
    localparam int WORD_WIDTH  = 2 * DATA_WIDTH;

    typedef logic [DATA_WIDTH-1:0] half_t;
    typedef logic [WORD_WIDTH-1:0] word_t;

    // One pipeline slot: data plus the frame tags and mode that travel with it.
    typedef struct packed {
        word_t data;
        logic  sop;
        logic  eop;
        logic  ifft;
    } beat_t;

    function automatic half_t cplx_re(input word_t w);
        return w[WORD_WIDTH-1:DATA_WIDTH];
    endfunction

    function automatic half_t cplx_im(input word_t w);
        return w[DATA_WIDTH-1:0];
    endfunction

    function automatic word_t cplx_pack(input half_t re, input half_t im);
        return {re, im};
    endfunction

endpackage

// File: rtl/complex_round_shift.sv
// Combinational round-half-up arithmetic right shift of both halves of a
// complex word. SHIFT=0 is a straight pass-through.
module complex_round_shift #(
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT      = 6
) (
    input  logic [2*DATA_WIDTH-1:0] data,
    output logic [2*DATA_WIDTH-1:0] result
);

    generate
        if (SHIFT == 0) begin : g_pass
            assign result = data;
        end else begin : g_shift
            localparam logic signed [DATA_WIDTH:0] HALF = (DATA_WIDTH+1)'(2 ** (SHIFT - 1));

            logic signed [DATA_WIDTH:0] re_sum;
            logic signed [DATA_WIDTH:0] im_sum;

            // One guard bit keeps the +HALF from wrapping at the positive rail.
            assign re_sum = $signed({data[2*DATA_WIDTH-1], data[2*DATA_WIDTH-1:DATA_WIDTH]}) + HALF;
            assign im_sum = $signed({data[DATA_WIDTH-1], data[DATA_WIDTH-1:0]}) + HALF;

            assign result = {DATA_WIDTH'(re_sum >>> SHIFT), DATA_WIDTH'(im_sum >>> SHIFT)};
        end
    endgenerate

endmodule

// File: rtl/mux_2_to_1.sv
// Generic two-input multiplexer; sel=0 picks a, sel=1 picks b.
module mux_2_to_1 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/fft_output_unswap_scale.sv
// FFT core output stage: undoes the IFFT real/imag swap, applies the 1/N
// rounding scale and tags frame start/end. Two-stage valid/ready pipeline.
module fft_output_unswap_scale #(
    parameter int FRAME_LEN   = fft_pkg::FRAME_LEN,
    parameter int SCALE_SHIFT = fft_pkg::SCALE_SHIFT
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [fft_pkg::WORD_WIDTH-1:0] In_Data,
    input  logic                          In_Valid,
    output logic                          In_Ready,
    input  logic                          In_Ifft,
    output logic [fft_pkg::WORD_WIDTH-1:0] Out_Data,
    output logic                          Out_Valid,
    input  logic                          Out_Ready,
    output logic                          Out_Sop,
    output logic                          Out_Eop
);

    import fft_pkg::*;

    localparam int                CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(FRAME_LEN - 1);

    logic             en;
    logic             beat;
    logic             first;
    logic             last;
    logic             word_mode;
    logic             mode_q;
    logic [CNT_W-1:0] count;

    half_t in_re, in_im, sw_re, sw_im;
    beat_t s1;
    logic  s1_vld;
    word_t scaled;
    word_t s2_data;

    // The whole pipe moves together; it only freezes when the output is held.
    assign en        = !Out_Valid || Out_Ready;
    assign In_Ready  = en;
    assign beat      = In_Valid && en;
    assign first     = (count == '0);
    assign last      = (count == LAST);
    assign word_mode = first ? In_Ifft : mode_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count  <= '0;
            mode_q <= 1'b0;
        end else if (beat) begin
            count <= last ? '0 : count + CNT_W'(1);
            if (first) mode_q <= In_Ifft;
        end
    end

    // Stage 1: swap halves back for IFFT frames.
    assign in_re = cplx_re(In_Data);
    assign in_im = cplx_im(In_Data);

    mux_2_to_1 #(.DATA_WIDTH(DATA_WIDTH)) u_mux_re (
        .sel (word_mode),
        .a   (in_re),
        .b   (in_im),
        .y   (sw_re)
    );

    mux_2_to_1 #(.DATA_WIDTH(DATA_WIDTH)) u_mux_im (
        .sel (word_mode),
        .a   (in_im),
        .b   (in_re),
        .y   (sw_im)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_vld <= 1'b0;
            s1     <= '0;
        end else if (en) begin
            s1_vld  <= In_Valid;
            s1.data <= cplx_pack(sw_re, sw_im);
            s1.sop  <= In_Valid && first;
            s1.eop  <= In_Valid && last;
            s1.ifft <= word_mode;
        end
    end

    // Stage 2: 1/N rounding scale, IFFT frames only.
    complex_round_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (SCALE_SHIFT)
    ) u_scale (
        .data   (s1.data),
        .result (scaled)
    );

    assign s2_data = s1.ifft ? scaled : s1.data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            Out_Sop   <= 1'b0;
            Out_Eop   <= 1'b0;
        end else if (en) begin
            Out_Valid <= s1_vld;
            Out_Data  <= s2_data;
            Out_Sop   <= s1_vld && s1.sop;
            Out_Eop   <= s1_vld && s1.eop;
        end
    end

endmodule

// File: tb/tb_fft_output_unswap_scale.sv
// Bench for fft_output_unswap_scale: frame-level reference model with a
// scoreboard queue, plus literal expectations for directed vectors.
module tb_fft_output_unswap_scale;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] In_Data;
    logic        In_Valid;
    logic        In_Ready;
    logic        In_Ifft;
    logic [31:0] Out_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Out_Sop;
    logic        Out_Eop;

    always #5 CLK = ~CLK;

    fft_output_unswap_scale dut (
        .CLK       (CLK),
        .RST       (RST),
        .In_Data   (In_Data),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .In_Ifft   (In_Ifft),
        .Out_Data  (Out_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Sop   (Out_Sop),
        .Out_Eop   (Out_Eop)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: IFFT output = swapped halves, each (x + 32) >> 6 with floor.
    function automatic logic [31:0] model(input logic [31:0] w, input bit ifft);
        int re;
        int im;
        if (!ifft) return w;
        re = $signed(w[15:0]);
        im = $signed(w[31:16]);
        re = (re + 32) >>> 6;
        im = (im + 32) >>> 6;
        return {re[15:0], im[15:0]};
    endfunction

    typedef struct {
        logic [31:0] data;
        bit          sop;
        bit          eop;
        int          t;
    } exp_t;

    exp_t        q[$];
    logic [31:0] got[$];
    int          cyc = 0;
    int          pos = 0;
    bit          mode = 0;
    bit          check_lat = 0;
    int          sop_cnt = 0;
    int          eop_cnt = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_sop;
    logic        prev_eop;

    // Compare process: inputs and outputs are stable at the falling edge.
    always @(negedge CLK) begin
        exp_t e;
        exp_t n;
        cyc++;
        if (RST) begin
            q.delete();
            pos        = 0;
            mode       = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", Out_Valid, 1);
                chk("stall_data", Out_Data, prev_data);
                chk("stall_flags", {Out_Sop, Out_Eop}, {prev_sop, prev_eop});
            end
            if (Out_Valid && !Out_Ready) chk("in_ready_full", In_Ready, 0);
            if (Out_Valid && Out_Ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", Out_Data, e.data);
                    chk("out_sop", Out_Sop, e.sop);
                    chk("out_eop", Out_Eop, e.eop);
                    if (check_lat) chk("latency", cyc - e.t, 2);
                    got.push_back(Out_Data);
                    sop_cnt += int'(Out_Sop);
                    eop_cnt += int'(Out_Eop);
                end
            end
            if (In_Valid && In_Ready) begin
                if (pos == 0) mode = In_Ifft;
                n.data = model(In_Data, mode);
                n.sop  = (pos == 0);
                n.eop  = (pos == 63);
                n.t    = cyc;
                q.push_back(n);
                pos = (pos + 1) % 64;
            end
            prev_stall = Out_Valid && !Out_Ready;
            prev_data  = Out_Data;
            prev_sop   = Out_Sop;
            prev_eop   = Out_Eop;
        end
    end

    task automatic send(input logic [31:0] w, input bit ifft);
        bit took;
        In_Data  = w;
        In_Ifft  = ifft;
        In_Valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            took = In_Ready;
            @(posedge CLK);
            #1;
            if (took) begin
                In_Valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 1, 0);
        In_Valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && q.size() != 0; k++) idle_cycle();
        chk("drain", q.size(), 0);
    endtask

    function automatic logic [31:0] ramp(input int i);
        logic [15:0] a;
        logic [15:0] b;
        a = 16'(i * 64);
        b = 16'(-(i * 128));
        return {a, b};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        RST       = 1'b1;
        In_Data   = '0;
        In_Valid  = 1'b0;
        In_Ifft   = 1'b0;
        Out_Ready = 1'b1;
        repeat (3) idle_cycle();
        chk("reset_valid", Out_Valid, 0);
        chk("reset_sop", Out_Sop, 0);
        chk("reset_eop", Out_Eop, 0);
        chk("reset_data", Out_Data, 0);
        RST = 1'b0;
        #1;
        chk("reset_in_ready", In_Ready, 1);

        // 1: FFT frame passes unchanged with exact 2-cycle latency
        check_lat = 1;
        base = got.size();
        for (int i = 0; i < 64; i++) send(32'h00010002 + 32'(i) * 32'h00010001, 1'b0);
        drain();
        check_lat = 0;
        chk("t1_count", got.size() - base, 64);
        chk("t1_w0", got[base], 32'h00010002);
        chk("t1_w63", got[base+63], 32'h00400041);

        // 2: IFFT swap and rounding scale
        base = got.size();
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = (i == 0) ? 32'h0040FFC0 : (i == 1) ? 32'h7FFF8000 :
                (i == 2) ? 32'h00200020 : 32'(i) * 32'h00030005;
            send(w, 1'b1);
        end
        drain();
        chk("t2_neg_pos", got[base], 32'hFFFF0001);
        chk("t2_rails", got[base+1], 32'hFE000200);
        chk("t2_half_up", got[base+2], 32'h00010001);

        // 3: backpressure, toggling then a 5-cycle hold-off
        base = got.size();
        fork
            for (int i = 0; i < 64; i++) send(32'hA5000000 + 32'(i) * 32'h00010003, 1'b0);
            begin
                for (int k = 0; k < 20; k++) begin
                    Out_Ready = ((k % 2) == 0);
                    idle_cycle();
                end
                Out_Ready = 1'b0;
                repeat (5) idle_cycle();
                Out_Ready = 1'b1;
            end
        join
        drain();
        chk("t3_count", got.size() - base, 64);

        // 4: mode changes mid-frame are ignored
        base = got.size();
        for (int i = 0; i < 64; i++) send(ramp(i), i >= 10);
        for (int i = 0; i < 64; i++) send(ramp(i), i == 0);
        drain();
        chk("t4_fft_kept", got[base+20], 32'h0500F600);
        chk("t4_ifft_kept", got[base+64+5], 32'hFFF60005);

        // 5: reset mid-frame with two words in flight
        for (int i = 0; i < 30; i++) send(32'h11110000 + 32'(i), 1'b0);
        #1;
        RST = 1'b1;
        #1;
        chk("t5_valid_cleared", Out_Valid, 0);
        chk("t5_sop_cleared", Out_Sop, 0);
        idle_cycle();
        RST = 1'b0;
        send(32'h12345678, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (Out_Valid) break;
        end
        chk("t5_first_sop", Out_Sop, 1);
        chk("t5_first_data", Out_Data, 32'h12345678);
        idle_cycle();
        for (int i = 1; i < 64; i++) send(32'h22220000 + 32'(i), 1'b0);
        drain();

        // 6: random bubbles across three frames
        sop_cnt = 0;
        eop_cnt = 0;
        base = got.size();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 64; i++) begin
                repeat ($urandom_range(0, 1)) idle_cycle();
                send($urandom, f == 1);
            end
        end
        drain();
        chk("t6_count", got.size() - base, 192);
        chk("t6_sops", sop_cnt, 3);
        chk("t6_eops", eop_cnt, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
